demux16_router: RTL and testbench

- Registered 1:2 demultiplexer for 16-bit datapath values.
- Steers one valid/ready input stream to one of two output channels, selected by `sel` at acceptance.
- Sits opposite the 16-bit 2:1 select mux in the RISC datapath. It fans a single result bus, e.g. the ALU/writeback result, out to two consumers, e.g. the register file write port and the memory store path.
- Each channel has one output register stage with backpressure, plus a per-channel delivery counter for debug/perf.

---
 rtl/demux16_router_pkg.sv | 17 +
 rtl/demux16_slot.sv | 65 ++++++
 rtl/demux16_router.sv | 80 ++++++++
 tb/tb_demux16_router.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux16_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux16_router_pkg
//  Description : Shared constants for the 16-bit 1:2 registered demux:
//                default widths and channel index encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package demux16_router_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 8;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

endpackage : demux16_router_pkg
`default_nettype wire

// File: rtl/demux16_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux16_slot
//  Description : One-entry output register with valid/ready handshake,
//                same-cycle drain-and-reload, and a wrapping delivery
//                counter with synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module demux16_slot
   import demux16_router_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_ready,
   input  logic              clr_cnt,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              ready_out,
   output logic [CNT_W-1:0]  cnt
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_deliver;

   assign w_deliver = r_valid && out_ready;
   // A slot being drained this cycle can take a new word without a bubble.
   assign ready_out = !r_valid || out_ready;

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign cnt       = r_cnt;

   // Slot register: a load always wins over a drain so drain+load keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= load_data;
      end else if (w_deliver) begin
         r_valid <= 1'b0;
      end
   end

   // Delivery counter: clear takes priority over a coincident increment; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr_cnt) begin
         r_cnt <= '0;
      end else if (w_deliver) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : demux16_slot
`default_nettype wire

// File: rtl/demux16_router.sv
`default_nettype none
// ============================================================================
//  Module      : demux16_router
//  Description : Registered 1:2 demultiplexer. Steers a valid/ready stream
//                to channel 0 or 1 according to in_sel at acceptance; each
//                channel has its own output slot, so a stalled channel only
//                blocks traffic aimed at it.
//  Revision    : 1.0  initial release
// ============================================================================
module demux16_router
   import demux16_router_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sel,
   input  logic [DATA_W-1:0] in_data,
   output logic              o0_valid,
   input  logic              o0_ready,
   output logic [DATA_W-1:0] o0_data,
   output logic              o1_valid,
   input  logic              o1_ready,
   output logic [DATA_W-1:0] o1_data,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   logic w_rdy0;
   logic w_rdy1;
   logic w_accept;
   logic w_load0;
   logic w_load1;

   // Readiness of the targeted slot only; the other channel never gates it.
   assign in_ready = (in_sel == CH1) ? w_rdy1 : w_rdy0;

   // in_valid gates first so an undriven in_sel while idle cannot load a slot.
   assign w_accept = in_valid && in_ready;
   assign w_load0  = w_accept && (in_sel == CH0);
   assign w_load1  = w_accept && (in_sel == CH1);

   demux16_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load0),
      .load_data (in_data),
      .out_ready (o0_ready),
      .clr_cnt   (clr_cnt),
      .out_valid (o0_valid),
      .out_data  (o0_data),
      .ready_out (w_rdy0),
      .cnt       (cnt0)
   );

   demux16_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load1),
      .load_data (in_data),
      .out_ready (o1_ready),
      .clr_cnt   (clr_cnt),
      .out_valid (o1_valid),
      .out_data  (o1_data),
      .ready_out (w_rdy1),
      .cnt       (cnt1)
   );

endmodule : demux16_router
`default_nettype wire

// File: tb/tb_demux16_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux16_router
//  Description : Directed self-checking bench for demux16_router.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux16_router;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sel;
   logic [15:0] in_data;
   logic        o0_valid;
   logic        o0_ready;
   logic [15:0] o0_data;
   logic        o1_valid;
   logic        o1_ready;
   logic [15:0] o1_data;
   logic        clr_cnt;
   logic [7:0]  cnt0;
   logic [7:0]  cnt1;

   int total = 0;
   int bad   = 0;

   demux16_router #(
      .DATA_W (16),
      .CNT_W  (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .o0_valid (o0_valid),
      .o0_ready (o0_ready),
      .o0_data  (o0_data),
      .o1_valid (o1_valid),
      .o1_ready (o1_ready),
      .o1_data  (o1_data),
      .clr_cnt  (clr_cnt),
      .cnt0     (cnt0),
      .cnt1     (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sel   = 1'b0;
      in_data  = 16'h0000;
      o0_ready = 1'b0;
      o1_ready = 1'b0;
      clr_cnt  = 1'b0;
      step();
      step();
      chk("rst_o0_valid", 32'(o0_valid), 32'd0);
      chk("rst_o1_valid", 32'(o1_valid), 32'd0);
      chk("rst_o0_data",  32'(o0_data),  32'd0);
      chk("rst_o1_data",  32'(o1_data),  32'd0);
      chk("rst_cnt0",     32'(cnt0),     32'd0);
      chk("rst_cnt1",     32'(cnt1),     32'd0);
      rst_n = 1'b1;
      step();

      // Basic steering
      o0_ready = 1'b1;
      o1_ready = 1'b1;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 16'hFFFF;
      #1;
      chk("steer_in_ready0", 32'(in_ready), 32'd1);
      step();
      chk("steer_o0_valid", 32'(o0_valid), 32'd1);
      chk("steer_o0_data",  32'(o0_data),  32'h0000FFFF);
      chk("steer_o1_idle",  32'(o1_valid), 32'd0);
      in_sel  = 1'b1;
      in_data = 16'h0000;
      step();
      chk("steer_o1_valid", 32'(o1_valid), 32'd1);
      chk("steer_o1_data",  32'(o1_data),  32'h00000000);
      chk("steer_o0_drain", 32'(o0_valid), 32'd0);
      in_valid = 1'b0;
      step();
      chk("steer_cnt0", 32'(cnt0), 32'd1);
      chk("steer_cnt1", 32'(cnt1), 32'd1);
      chk("steer_o1_drain", 32'(o1_valid), 32'd0);

      // Backpressure isolation
      o0_ready = 1'b0;
      o1_ready = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 16'h1234;
      step();
      chk("bp_o0_1234", 32'(o0_data), 32'h00001234);
      in_data = 16'hABCD;
      #1;
      chk("bp_abcd_blocked", 32'(in_ready), 32'd0);
      step();
      chk("bp_o0_hold", 32'(o0_data), 32'h00001234);
      in_sel  = 1'b1;
      in_data = 16'h5555;
      #1;
      chk("bp_5555_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp_o1_valid", 32'(o1_valid), 32'd1);
      chk("bp_o1_5555",  32'(o1_data),  32'h00005555);
      chk("bp_o0_hold2", 32'(o0_data),  32'h00001234);
      in_sel  = 1'b0;
      in_data = 16'hABCD;
      #1;
      chk("bp_abcd_blocked2", 32'(in_ready), 32'd0);
      step();
      chk("bp_o0_hold3", 32'(o0_data), 32'h00001234);
      o0_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp_o0_abcd",  32'(o0_data),  32'h0000ABCD);
      chk("bp_o0_valid", 32'(o0_valid), 32'd1);
      chk("bp_cnt0_2",   32'(cnt0),     32'd2);
      in_valid = 1'b0;
      step();
      chk("bp_cnt0_3",      32'(cnt0),     32'd3);
      chk("bp_o0_empty",    32'(o0_valid), 32'd0);
      chk("bp_o1_still",    32'(o1_data),  32'h00005555);
      o1_ready = 1'b1;
      step();
      chk("bp_cnt1_2",   32'(cnt1),     32'd2);
      chk("bp_o1_empty", 32'(o1_valid), 32'd0);

      // Clear, then full-throughput burst on channel 1
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("clr_cnt0", 32'(cnt0), 32'd0);
      chk("clr_cnt1", 32'(cnt1), 32'd0);
      in_sel   = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'(i);
         #1;
         chk("burst_in_ready", 32'(in_ready), 32'd1);
         step();
         chk("burst_o1_valid", 32'(o1_valid), 32'd1);
         chk("burst_o1_data",  32'(o1_data),  32'(i));
      end
      in_valid = 1'b0;
      step();
      chk("burst_cnt1",  32'(cnt1),     32'd10);
      chk("burst_empty", 32'(o1_valid), 32'd0);

      // Counter wrap on channel 0
      in_sel   = 1'b0;
      in_valid = 1'b1;
      o0_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 16'(i);
         step();
      end
      chk("wrap_cnt0_255", 32'(cnt0), 32'd255);
      chk("wrap_last_data", 32'(o0_data), 32'h000000FF);
      in_valid = 1'b0;
      step();
      chk("wrap_cnt0_0", 32'(cnt0), 32'd0);

      // Clear coincident with a channel 1 delivery
      o1_ready = 1'b0;
      in_sel   = 1'b1;
      in_data  = 16'h0F0F;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("clrinc_loaded", 32'(o1_valid), 32'd1);
      o1_ready = 1'b1;
      clr_cnt  = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("clrinc_cnt1",  32'(cnt1),     32'd0);
      chk("clrinc_drain", 32'(o1_valid), 32'd0);

      // Idle with X on in_sel/in_data
      in_valid = 1'b0;
      in_sel   = 1'bx;
      in_data  = 16'hxxxx;
      for (int i = 0; i < 5; i++) step();
      chk("idle_o0_valid", 32'(o0_valid), 32'd0);
      chk("idle_o1_valid", 32'(o1_valid), 32'd0);
      chk("idle_cnt0",     32'(cnt0),     32'd0);
      chk("idle_cnt1",     32'(cnt1),     32'd0);

      // Fill both slots (with a same-cycle drain+reload on ch0), then reset mid-cycle
      o0_ready = 1'b1;
      o1_ready = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 16'h1111;
      step();
      in_data = 16'h3333;
      step();
      chk("reload_o0_valid", 32'(o0_valid), 32'd1);
      chk("reload_o0_data",  32'(o0_data),  32'h00003333);
      chk("reload_cnt0",     32'(cnt0),     32'd1);
      o0_ready = 1'b0;
      in_sel   = 1'b1;
      in_data  = 16'h2222;
      step();
      in_valid = 1'b0;
      chk("full_o0", 32'(o0_valid), 32'd1);
      chk("full_o1", 32'(o1_data),  32'h00002222);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_o0_valid", 32'(o0_valid), 32'd0);
      chk("arst_o1_valid", 32'(o1_valid), 32'd0);
      chk("arst_o0_data",  32'(o0_data),  32'd0);
      chk("arst_o1_data",  32'(o1_data),  32'd0);
      chk("arst_cnt0",     32'(cnt0),     32'd0);
      chk("arst_cnt1",     32'(cnt1),     32'd0);
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 16'h7777;
      step();
      chk("arst_hold_valid", 32'(o0_valid), 32'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux16_router
`default_nettype wire
